// File: rtl/alu_opcodes_pkg.sv
// Opcode encodings shared with the core's single-cycle alu.
// The sequencer only ever issues ADD, SUB and the unsigned
// greater-or-equal compare.
package alu_opcodes_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_GEU = 5'd7;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the core's
// single-cycle alu. MUL is shift-and-add, DIVU/REMU are restoring
// shift-compare-subtract. While busy it owns the alu inputs; in IDLE
// it parks the alu on a harmless ADD of zeros.
module alu_muldiv_seq
  import alu_opcodes_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_op_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_flag_i
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MUL_STEP,
    DIV_CMP,
    DIV_SUB,
    DONE
  } state_t;

  state_t      state_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] divisor_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic [31:0] shiftRem_d;
  logic        quoBit_d;
  logic [31:0] quo_d;
  logic [31:0] acc_d;
  logic [31:0] mplierShift_d;
  logic        mulLast_d;

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Next-step datapath values; the last step's result is taken from these
  // so result_o is already correct in the cycle valid_o is high.
  always_comb begin
    shiftRem_d    = {rem_q[30:0], quo_q[31]};
    quoBit_d      = rem_q[31] | alu_flag_i;
    quo_d         = {quo_q[30:0], quoBit_d};
    acc_d         = mplier_q[0] ? alu_result_i : acc_q;
    mplierShift_d = mplier_q >> 1;
    mulLast_d     = (cnt_q == 5'd31) || (EARLY_EXIT && (mplierShift_d == 32'd0));
  end

  // The alu operands follow the state directly so each step's alu result
  // is available within the same cycle.
  always_comb begin
    alu_a_o  = 32'd0;
    alu_b_o  = 32'd0;
    alu_op_o = ALU_ADD;
    case (state_q)
      MUL_STEP: begin
        alu_a_o  = acc_q;
        alu_b_o  = mcand_q;
        alu_op_o = ALU_ADD;
      end
      DIV_CMP: begin
        alu_a_o  = shiftRem_d;
        alu_b_o  = divisor_q;
        alu_op_o = ALU_GEU;
      end
      DIV_SUB: begin
        alu_a_o  = rem_q;
        alu_b_o  = divisor_q;
        alu_op_o = ALU_SUB;
      end
      default: begin
        alu_a_o  = 32'd0;
        alu_b_o  = 32'd0;
        alu_op_o = ALU_ADD;
      end
    endcase
  end

  // Sequencer state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= 32'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      divisor_q <= 32'd0;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            op_q    <= op_i;
            cnt_q   <= 5'd0;
            ready_q <= 1'b0;
            case (op_i)
              OP_MUL: begin
                acc_q    <= 32'd0;
                mcand_q  <= a_i;
                mplier_q <= b_i;
                state_q  <= MUL_STEP;
              end
              OP_DIVU, OP_REMU: begin
                if (b_i != 32'd0) begin
                  rem_q     <= 32'd0;
                  quo_q     <= a_i;
                  divisor_q <= b_i;
                  state_q   <= DIV_CMP;
                end else begin
                  result_q <= (op_i == OP_DIVU) ? 32'hFFFF_FFFF : a_i;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
                end
              end
              default: begin
                result_q <= 32'd0;
                valid_q  <= 1'b1;
                state_q  <= DONE;
              end
            endcase
          end
        end

        MUL_STEP: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplierShift_d;
          cnt_q    <= cnt_q + 5'd1;
          if (mulLast_d) begin
            result_q <= acc_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end

        DIV_CMP: begin
          rem_q <= shiftRem_d;
          quo_q <= quo_d;
          if (quoBit_d) begin
            state_q <= DIV_SUB;
          end else if (cnt_q == 5'd31) begin
            result_q <= (op_q == OP_DIVU) ? quo_d : shiftRem_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end

        DIV_SUB: begin
          rem_q <= alu_result_i;
          if (cnt_q == 5'd31) begin
            result_q <= (op_q == OP_DIVU) ? quo_q : alu_result_i;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q   <= cnt_q + 5'd1;
            state_q <= DIV_CMP;
          end
        end

        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: two instances (early exit on and
// off), each paired with a behavioural model of the core's alu.
module tb_alu_muldiv_seq;
   import alu_opcodes_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] aIn = 32'd0;
   logic [31:0] bIn = 32'd0;
   logic        ready, valid;
   logic [31:0] result, aluA, aluB, aluRes;
   logic [4:0]  aluOp;
   logic        aluFlag;

   logic        req0 = 1'b0;
   logic [1:0]  op0 = 2'b00;
   logic [31:0] aIn0 = 32'd0;
   logic [31:0] bIn0 = 32'd0;
   logic        ready0, valid0;
   logic [31:0] result0, aluA0, aluB0, aluRes0;
   logic [4:0]  aluOp0;
   logic        aluFlag0;

   int checks = 0;
   int errors = 0;
   int geuCount, subCount, badSub;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Behavioural stand-in for the core alu: ADD/SUB give a result,
   // GEU raises the flag when a >= b unsigned.
   function automatic logic [32:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] opc);
      logic [32:0] r;
      r = 33'd0;
      if (opc == ALU_ADD)      r = {1'b0, a + b};
      else if (opc == ALU_SUB) r = {1'b0, a - b};
      else if (opc == ALU_GEU) r = {(a >= b), 32'd0};
      return r;
   endfunction

   assign {aluFlag, aluRes}   = aluModel(aluA, aluB, aluOp);
   assign {aluFlag0, aluRes0} = aluModel(aluA0, aluB0, aluOp0);

   alu_muldiv_seq #(.EARLY_EXIT(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .a_i(aIn), .b_i(bIn),
      .ready_o(ready), .valid_o(valid), .result_o(result),
      .alu_a_o(aluA), .alu_b_o(aluB), .alu_op_o(aluOp),
      .alu_result_i(aluRes), .alu_flag_i(aluFlag)
   );

   alu_muldiv_seq #(.EARLY_EXIT(1'b0)) dutSlow (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .op_i(op0), .a_i(aIn0), .b_i(bIn0),
      .ready_o(ready0), .valid_o(valid0), .result_o(result0),
      .alu_a_o(aluA0), .alu_b_o(aluB0), .alu_op_o(aluOp0),
      .alu_result_i(aluRes0), .alu_flag_i(aluFlag0)
   );

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request on the chosen instance, then wait (bounded) for
   // valid_o, returning the result and the accept-to-valid latency. The
   // alu opcode trace of the busy cycles is tallied along the way.
   task automatic applyStimulus(input bit useSlow, input logic [1:0] opc,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
      bit gotValid;
      logic [4:0] prevOp, curOp;
      gotValid = 1'b0;
      res = 32'hDEAD_BEEF;
      lat = 0;
      geuCount = 0;
      subCount = 0;
      badSub = 0;
      prevOp = ALU_ADD;
      @(negedge clk);
      if (useSlow) begin req0 = 1'b1; op0 = opc; aIn0 = a; bIn0 = b; end
      else begin req = 1'b1; op = opc; aIn = a; bIn = b; end
      @(posedge clk);
      #1;
      req = 1'b0;
      req0 = 1'b0;
      for (int i = 1; i <= 200 && !gotValid; i++) begin
         @(negedge clk);
         lat = i;
         curOp = useSlow ? aluOp0 : aluOp;
         if (useSlow ? valid0 : valid) begin
            gotValid = 1'b1;
            res = useSlow ? result0 : result;
         end else begin
            if (curOp == ALU_GEU) geuCount++;
            if (curOp == ALU_SUB) begin
               subCount++;
               if (prevOp != ALU_GEU) badSub++;
            end
            prevOp = curOp;
         end
      end
      checks++;
      assert (gotValid)
      else begin
         errors++;
         $error("[TB] FAIL valid_timeout: observed no valid_o in %0d cycles, expected a pulse", lat);
      end
   endtask

   logic [31:0] res;
   int          lat;
   int          sawValid;

   // Directed sequence of scenarios with hand-computed expectations.
   initial begin
      $display("[TB] starting alu_muldiv_seq bench");
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_alu_a", aluA, 32'd0);
      checkOutput("rst_alu_b", aluB, 32'd0);
      checkOutput("rst_alu_op", 32'(aluOp), 32'(ALU_ADD));
      rst = 1'b0;

      // Multiply with and without early exit.
      applyStimulus(1'b0, 2'b00, 32'd7, 32'd6, res, lat);
      checkOutput("mul7x6_res", res, 32'd42);
      checkOutput("mul7x6_lat", 32'(lat), 32'd4);
      applyStimulus(1'b1, 2'b00, 32'd7, 32'd6, res, lat);
      checkOutput("mul7x6_noee_res", res, 32'd42);
      checkOutput("mul7x6_noee_lat", 32'(lat), 32'd33);
      applyStimulus(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
      checkOutput("mulmax_res", res, 32'h0000_0001);
      checkOutput("mulmax_lat", 32'(lat), 32'd33);
      applyStimulus(1'b0, 2'b00, 32'd5, 32'd0, res, lat);
      checkOutput("mul5x0_res", res, 32'd0);
      checkOutput("mul5x0_lat", 32'(lat), 32'd2);
      applyStimulus(1'b0, 2'b00, 32'h0001_2345, 32'h0000_0100, res, lat);
      checkOutput("mulshift_res", res, 32'h0123_4500);

      // Division, including the opcode trace: 14 = 0b1110 has three ones.
      applyStimulus(1'b0, 2'b10, 32'd100, 32'd7, res, lat);
      checkOutput("divu100_7_res", res, 32'd14);
      checkOutput("divu100_7_lat", 32'(lat), 32'd36);
      checkOutput("divu100_7_geu", 32'(geuCount), 32'd32);
      checkOutput("divu100_7_sub", 32'(subCount), 32'd3);
      checkOutput("divu100_7_order", 32'(badSub), 32'd0);
      applyStimulus(1'b0, 2'b11, 32'd100, 32'd7, res, lat);
      checkOutput("remu100_7_res", res, 32'd2);
      applyStimulus(1'b0, 2'b10, 32'hFFFF_FFFF, 32'h8000_0000, res, lat);
      checkOutput("divu_big_res", res, 32'd1);
      checkOutput("divu_big_lat", 32'(lat), 32'd34);
      applyStimulus(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h8000_0000, res, lat);
      checkOutput("remu_big_res", res, 32'h7FFF_FFFF);
      applyStimulus(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0001_0000, res, lat);
      checkOutput("divu_slow_res", res, 32'h0000_DEAD);

      // Divide by zero and the reserved opcode complete in one cycle.
      applyStimulus(1'b0, 2'b10, 32'd5, 32'd0, res, lat);
      checkOutput("divu_by0_res", res, 32'hFFFF_FFFF);
      checkOutput("divu_by0_lat", 32'(lat), 32'd1);
      applyStimulus(1'b0, 2'b11, 32'd5, 32'd0, res, lat);
      checkOutput("remu_by0_res", res, 32'd5);
      checkOutput("remu_by0_lat", 32'(lat), 32'd1);
      applyStimulus(1'b0, 2'b01, 32'd9, 32'd9, res, lat);
      checkOutput("rsvd_res", res, 32'd0);
      checkOutput("rsvd_lat", 32'(lat), 32'd1);

      // Requests while busy are dropped; the held request is taken once
      // ready_o rises again.
      @(negedge clk);
      req = 1'b1; op = 2'b10; aIn = 32'd100; bIn = 32'd7;
      @(posedge clk);
      #1;
      op = 2'b00; aIn = 32'd3; bIn = 32'd4;
      sawValid = 0;
      for (int i = 0; i < 100 && sawValid == 0; i++) begin
         @(negedge clk);
         if (valid) begin
            sawValid = 1;
            checkOutput("busy_ignore_res", result, 32'd14);
         end
      end
      checkOutput("busy_ignore_seen", 32'(sawValid), 32'd1);
      @(negedge clk);
      checkOutput("busy_ready_back", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0;
      sawValid = 0;
      for (int i = 0; i < 100 && sawValid == 0; i++) begin
         @(negedge clk);
         if (valid) begin
            sawValid = 1;
            checkOutput("held_req_res", result, 32'd12);
         end
      end
      checkOutput("held_req_seen", 32'(sawValid), 32'd1);

      // Reset in the middle of a long multiply.
      @(negedge clk);
      req = 1'b1; op = 2'b00; aIn = 32'd5; bIn = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      req = 1'b0;
      sawValid = 0;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         if (valid) sawValid = 1;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      if (valid) sawValid = 1;
      checkOutput("abort_no_valid", 32'(sawValid), 32'd0);
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_result", result, 32'd0);
      checkOutput("abort_alu_a", aluA, 32'd0);
      checkOutput("abort_alu_b", aluB, 32'd0);
      checkOutput("abort_alu_op", 32'(aluOp), 32'(ALU_ADD));
      applyStimulus(1'b0, 2'b00, 32'd3, 32'd3, res, lat);
      checkOutput("after_abort_res", res, 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that runs unsigned MUL (low word), DIVU and REMU on the core's existing single-cycle `alu` rather than on a dedicated multiplier or divider. It owns the ALU's operand and opcode inputs while busy. It iterates shift-and-add for multiplication and restoring shift-compare-subtract for division. It sits beside the execute stage; the core stalls on `ready_o` low. Opcode encodings come from `alu_opcodes_pkg` (ALU_ADD, ALU_SUB, ALU_GEU).

## Interface
- EARLY_EXIT, 1, when 1 MUL terminates as soon as the remaining multiplier is zero; when 0 MUL always takes 32 steps
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_i  in  1  operation request
- op_i  in  2  00 MUL, 01 reserved, 10 DIVU, 11 REMU
- a_i  in  32  multiplicand / dividend
- b_i  in  32  multiplier / divisor
- ready_o  out  1  high only in IDLE; request accepted when req_i && ready_o
- valid_o  out  1  one-cycle pulse, result_o valid
- result_o  out  32  registered result, held until next valid_o
- alu_a_o  out  32  ALU operand A
- alu_b_o  out  32  ALU operand B
- alu_op_o  out  5  ALU opcode
- alu_result_i  in  32  ALU result_o
- alu_flag_i  in  1  ALU flag_o

## Operation
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE.
- Internal registers: acc, mcand, mplier, rem, quo, divisor (all 32 bit), cnt (5 bit), op.
- IDLE:
  - ALU driven with a=0, b=0, op=ALU_ADD.
  - On acceptance, operands and op are latched.
  - MUL: acc=0, mcand=a_i, mplier=b_i → MUL_STEP.
  - DIVU/REMU with b_i≠0: rem=0, quo=a_i, divisor=b_i, cnt=0 → DIV_CMP.
  - DIVU/REMU with b_i==0: straight to DONE with result 0xFFFFFFFF (DIVU) or a_i (REMU).
  - Reserved op: straight to DONE with result 0.
  - req_i while not IDLE is ignored; no queueing.
- MUL_STEP:
  - Drive alu_a=acc, alu_b=mcand, alu_op=ALU_ADD.
  - If mplier[0]: acc<=alu_result_i.
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt++.
  - Exit to DONE when cnt==31, or when EARLY_EXIT and (mplier>>1)==0.
  - Result is the low 32 bits (mod 2^32).
- DIV_CMP:
  - s={rem[30:0],quo[31]}; drive alu_a=s, alu_b=divisor, alu_op=ALU_GEU.
  - q=rem[31] | alu_flag_i. rem[31] covers the 33-bit overflow when divisor ≥ 2^31.
  - rem<=s, quo<={quo[30:0],q}.
  - If q → DIV_SUB; else if cnt==31 → DONE; else cnt++, stay.
- DIV_SUB:
  - Drive alu_a=rem, alu_b=divisor, alu_op=ALU_SUB; rem<=alu_result_i (mod 2^32 is exact).
  - If cnt==31 → DONE; else cnt++ → DIV_CMP.
- DONE:
  - result_o<=acc (MUL), quo (DIVU), rem (REMU), or the special value.
  - valid_o=1, ALU back to idle drive → IDLE.
- ALU drive is combinational from state; the ALU is not used by anyone else while busy.

## Timing
- Reset: state IDLE, ready_o=1, valid_o=0, result_o=0, alu_a_o=0, alu_b_o=0, alu_op_o=ALU_ADD, all internal registers 0.
- Reset mid-operation aborts with no valid_o; the next cycle accepts requests.
- Latency is counted as cycles from the accepting edge to the valid_o cycle:
  - MUL: steps+1; steps=32, or fewer with EARLY_EXIT (b_i==0 → 1 step).
  - DIVU/REMU: 32 + popcount(quotient) + 1.
  - Divide-by-zero or reserved op: 1.
- ready_o returns high the cycle after valid_o, so back-to-back issue is one cycle apart from valid_o.
- result_o changes only on the valid_o cycle.

## Test plan
- MUL 7×6, EARLY_EXIT=1 → result_o=42, valid_o 4 cycles after accept; with EARLY_EXIT=0 → 33 cycles.
- MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 after 33 cycles; MUL 5×0 → 0 after 2 cycles (EARLY_EXIT=1).
- DIVU 100/7 → 14 after 36 cycles; REMU 100/7 → 2; ALU opcode trace alternates ALU_GEU/ALU_SUB exactly on the 3 quotient-one bits.
- DIVU 0xFFFFFFFF/0x80000000 → 1; REMU → 0x7FFFFFFF (rem[31] path); DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both 1 cycle.
- req_i held high with new operands during a busy DIVU → ignored, original result returned, then new request accepted when ready_o rises.
- rst_i asserted at cycle 10 of a MUL → no valid_o, all outputs at reset values next cycle, fresh MUL 3×3 → 9.
